// File: rtl/crossing_gen_pkg.sv
// Shared types and helpers for the crossing stimulus generator.
// The period split functions work on 32-bit values; callers truncate to their counter width.
package crossing_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_FLUSH
  } state_t;

  localparam int unsigned PRE_LEN   = 2;
  localparam int unsigned FLUSH_LEN = 2;

  // Periods below 2 cannot hold both a high and a low sample.
  function automatic int unsigned clamp_period(input int unsigned n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic int unsigned half_high(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  function automatic int unsigned half_low(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/crossing_gen_phase_down_cnt.sv
// Loadable down-counter that parks at zero and flags it.
// Load has priority over the count enable.
module phase_down_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/crossing_gen.sv
// Emits a framed sample stream with an upward LIMIT crossing every N samples.
// Control (period_ready) follows the state; signal_out, busy and done are registered one sample behind it.
module crossing_gen
  import crossing_gen_pkg::*;
#(
  parameter int          LIMIT       = -5,
  parameter int unsigned W_N_MAX     = 8,
  parameter int          HIGH_LEVEL  = 100,
  parameter int          LOW_LEVEL   = -100,
  parameter int unsigned NUM_PERIODS = 3
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic [W_N_MAX-1:0]  period_in,
  input  logic                period_valid,
  output logic                period_ready,
  input  logic                abort,
  output logic signed [31:0]  signal_out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PW = $clog2(NUM_PERIODS + 1);
  localparam logic [PW-1:0] LAST_PERIOD = PW'(NUM_PERIODS - 1);

  // Levels are pinned to the correct side of LIMIT even if misconfigured.
  localparam int HIGH_EFF = (HIGH_LEVEL > LIMIT) ? HIGH_LEVEL : LIMIT + 1;
  localparam int LOW_EFF  = (LOW_LEVEL <= LIMIT) ? LOW_LEVEL : LIMIT;

  state_t state, next_state;

  logic [W_N_MAX-1:0] n_reg;
  logic [W_N_MAX-1:0] h_len;
  logic [W_N_MAX-1:0] l_len;
  logic [W_N_MAX-1:0] load_val;
  logic [W_N_MAX-1:0] phase;
  logic               load;
  logic               en;
  logic               phase_zero;
  logic               xfer;
  logic [PW-1:0]      pcnt;
  logic               last_period;
  logic signed [31:0] sample_next;
  logic               done_next;
  logic               busy_next;

  assign period_ready = (state == ST_IDLE);
  assign xfer         = period_valid && period_ready;
  assign h_len        = W_N_MAX'(half_high(32'(n_reg)));
  assign l_len        = W_N_MAX'(half_low(32'(n_reg)));
  assign last_period  = (pcnt == LAST_PERIOD);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      n_reg <= '0;
    end else if (xfer) begin
      n_reg <= W_N_MAX'(clamp_period(32'(period_in)));
    end
  end

  phase_down_cnt #(
    .W (W_N_MAX)
  ) u_phase (
    .clk      (clk),
    .reset_l  (reset_l),
    .load     (load),
    .en       (en),
    .load_val (load_val),
    .count    (phase),
    .zero     (phase_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      pcnt <= '0;
    end else if (state == ST_IDLE) begin
      pcnt <= '0;
    end else if ((state == ST_LOW) && phase_zero && !abort) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (xfer) next_state = ST_PRE;
      ST_PRE: begin
        if (abort)           next_state = ST_FLUSH;
        else if (phase_zero) next_state = ST_HIGH;
      end
      ST_HIGH: begin
        if (abort)           next_state = ST_FLUSH;
        else if (phase_zero) next_state = ST_LOW;
      end
      ST_LOW: begin
        if (abort)           next_state = ST_FLUSH;
        else if (phase_zero) next_state = last_period ? ST_TAIL : ST_HIGH;
      end
      ST_TAIL:  next_state = ST_FLUSH;
      ST_FLUSH: if (phase_zero) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Every state change reloads the phase counter with the new state's length minus one.
  always_comb begin
    load     = (next_state != state);
    en       = (state != ST_IDLE);
    load_val = '0;
    case (next_state)
      ST_PRE:   load_val = W_N_MAX'(PRE_LEN - 1);
      ST_HIGH:  load_val = h_len - 1'b1;
      ST_LOW:   load_val = l_len - 1'b1;
      ST_FLUSH: load_val = W_N_MAX'(FLUSH_LEN - 1);
      default:  load_val = '0;
    endcase
  end

  always_comb begin
    sample_next = '0;
    done_next   = 1'b0;
    busy_next   = (state != ST_IDLE);
    case (state)
      ST_PRE, ST_LOW:   sample_next = LOW_EFF;
      ST_HIGH, ST_TAIL: sample_next = HIGH_EFF;
      ST_FLUSH:         done_next   = phase_zero;
      default:          sample_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      signal_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      signal_out <= sample_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule
